// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: two result sources, register-file write port, scoreboard access
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            exValid_i;
    logic [4:0]      exRd_i;
    logic [XLEN-1:0] exData_i;
    logic            exReady_o;

    logic            memValid_i;
    logic [4:0]      memRd_i;
    logic [XLEN-1:0] memData_i;
    logic            memReady_o;

    logic            regWrite_o;
    logic [4:0]      rdNum_o;
    logic [XLEN-1:0] rdVal_o;

    logic            issueValid_i;
    logic [4:0]      issueRd_i;
    logic [4:0]      rs1Num_i;
    logic [4:0]      rs2Num_i;
    logic            hazard_o;
    logic            flush_i;

    modport slave (
        input  exValid_i, exRd_i, exData_i,
        output exReady_o,
        input  memValid_i, memRd_i, memData_i,
        output memReady_o,
        output regWrite_o, rdNum_o, rdVal_o,
        input  issueValid_i, issueRd_i, rs1Num_i, rs2Num_i, flush_i,
        output hazard_o
    );

    modport master (
        output exValid_i, exRd_i, exData_i,
        input  exReady_o,
        output memValid_i, memRd_i, memData_i,
        input  memReady_o,
        input  regWrite_o, rdNum_o, rdVal_o,
        output issueValid_i, issueRd_i, rs1Num_i, rs2Num_i, flush_i,
        input  hazard_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter with registered register-file write and pending-write scoreboard
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    typedef enum logic {
        GRANT_EX  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e          last_grant_q, last_grant_d;
    logic            reg_write_q,  reg_write_d;
    logic [4:0]      rd_num_q,     rd_num_d;
    logic [XLEN-1:0] rd_val_q,     rd_val_d;
    logic [NREG-1:0] pending_q,    pending_d;

    logic            grant_ex;
    logic            grant_mem;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    // Round-robin: on a conflict the source that did not win last time is served.
    always_comb begin
        grant_ex  = 1'b0;
        grant_mem = 1'b0;
        if (bus.exValid_i && bus.memValid_i) begin
            if (last_grant_q == GRANT_EX) begin
                grant_mem = 1'b1;
            end else begin
                grant_ex = 1'b1;
            end
        end else if (bus.exValid_i) begin
            grant_ex = 1'b1;
        end else if (bus.memValid_i) begin
            grant_mem = 1'b1;
        end
    end

    always_comb begin
        win_rd   = 5'd0;
        win_data = '0;
        if (grant_mem) begin
            win_rd   = bus.memRd_i;
            win_data = bus.memData_i;
        end else if (grant_ex) begin
            win_rd   = bus.exRd_i;
            win_data = bus.exData_i;
        end
    end

    // Issue is younger than the retiring write, so its set is applied last.
    always_comb begin
        last_grant_d = last_grant_q;
        reg_write_d  = 1'b0;
        rd_num_d     = rd_num_q;
        rd_val_d     = rd_val_q;
        pending_d    = bus.flush_i ? '0 : pending_q;

        if (grant_ex || grant_mem) begin
            last_grant_d      = grant_mem ? GRANT_MEM : GRANT_EX;
            reg_write_d       = (win_rd != 5'd0);
            rd_num_d          = win_rd;
            rd_val_d          = win_data;
            pending_d[win_rd] = 1'b0;
        end

        if (bus.issueValid_i && (bus.issueRd_i != 5'd0)) begin
            pending_d[bus.issueRd_i] = 1'b1;
        end

        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_EX;
            reg_write_q  <= 1'b0;
            rd_num_q     <= 5'd0;
            rd_val_q     <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            rd_num_q     <= rd_num_d;
            rd_val_q     <= rd_val_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.exReady_o  = grant_ex  & rst_n;
    assign bus.memReady_o = grant_mem & rst_n;

    assign bus.regWrite_o = reg_write_q;
    assign bus.rdNum_o    = rd_num_q;
    assign bus.rdVal_o    = rd_val_q;

    // A write retiring this cycle still shows as a hazard; the bit drops next cycle.
    assign bus.hazard_o   = pending_q[bus.rs1Num_i] | pending_q[bus.rs2Num_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        bus.exValid_i    = 1'b1;
        bus.exRd_i       = 5'd5;
        bus.exData_i     = 32'h0;
        bus.memValid_i   = 1'b0;
        bus.memRd_i      = 5'd0;
        bus.memData_i    = 32'h0;
        bus.issueValid_i = 1'b0;
        bus.issueRd_i    = 5'd0;
        bus.rs1Num_i     = 5'd0;
        bus.rs2Num_i     = 5'd0;
        bus.flush_i      = 1'b0;

        // reset state
        #1;
        check("rst_exReady",  {31'd0, bus.exReady_o},  32'd0);
        check("rst_memReady", {31'd0, bus.memReady_o}, 32'd0);
        check("rst_regWrite", {31'd0, bus.regWrite_o}, 32'd0);
        check("rst_rdNum",    {27'd0, bus.rdNum_o},    32'd0);
        check("rst_rdVal",    bus.rdVal_o,             32'd0);
        check("rst_hazard",   {31'd0, bus.hazard_o},   32'd0);
        #12;
        bus.exValid_i = 1'b0;
        rst_n = 1'b1;
        tick();

        // EX only, with rd=5 pending beforehand
        bus.issueValid_i = 1'b1;
        bus.issueRd_i    = 5'd5;
        tick();
        bus.issueValid_i = 1'b0;
        bus.rs1Num_i     = 5'd5;
        #1;
        check("t1_hazard_set", {31'd0, bus.hazard_o}, 32'd1);
        bus.exValid_i = 1'b1;
        bus.exRd_i    = 5'd5;
        bus.exData_i  = 32'hDEADBEEF;
        #1;
        check("t1_exReady",      {31'd0, bus.exReady_o},  32'd1);
        check("t1_memReady",     {31'd0, bus.memReady_o}, 32'd0);
        check("t1_hazard_grant", {31'd0, bus.hazard_o},   32'd1);
        tick();
        bus.exValid_i = 1'b0;
        check("t1_regWrite", {31'd0, bus.regWrite_o}, 32'd1);
        check("t1_rdNum",    {27'd0, bus.rdNum_o},    32'd5);
        check("t1_rdVal",    bus.rdVal_o,             32'hDEADBEEF);
        #1;
        check("t1_hazard_clr", {31'd0, bus.hazard_o}, 32'd0);
        tick();
        check("t1_idle_regWrite", {31'd0, bus.regWrite_o}, 32'd0);
        check("t1_idle_rdNum",    {27'd0, bus.rdNum_o},    32'd5);
        check("t1_idle_rdVal",    bus.rdVal_o,             32'hDEADBEEF);

        // conflict fairness: MEM, EX, MEM, EX
        bus.rs1Num_i   = 5'd0;
        bus.exValid_i  = 1'b1;
        bus.exRd_i     = 5'd3;
        bus.exData_i   = 32'h11;
        bus.memValid_i = 1'b1;
        bus.memRd_i    = 5'd4;
        bus.memData_i  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cf_memReady", {31'd0, bus.memReady_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("cf_exReady",  {31'd0, bus.exReady_o},  (i % 2 == 0) ? 32'd0 : 32'd1);
            check("cf_exclusive", {31'd0, bus.exReady_o & bus.memReady_o}, 32'd0);
            tick();
            check("cf_regWrite", {31'd0, bus.regWrite_o}, 32'd1);
            check("cf_rdNum", {27'd0, bus.rdNum_o}, (i % 2 == 0) ? 32'd4 : 32'd3);
            check("cf_rdVal", bus.rdVal_o, (i % 2 == 0) ? 32'h22 : 32'h11);
        end
        bus.exValid_i  = 1'b0;
        bus.memValid_i = 1'b0;

        // scoreboard hazard through a MEM write
        bus.issueValid_i = 1'b1;
        bus.issueRd_i    = 5'd7;
        tick();
        bus.issueValid_i = 1'b0;
        bus.rs1Num_i     = 5'd7;
        #1;
        check("t3_hazard_set", {31'd0, bus.hazard_o}, 32'd1);
        bus.memValid_i = 1'b1;
        bus.memRd_i    = 5'd7;
        bus.memData_i  = 32'h77;
        #1;
        check("t3_memReady",     {31'd0, bus.memReady_o}, 32'd1);
        check("t3_hazard_grant", {31'd0, bus.hazard_o},   32'd1);
        tick();
        bus.memValid_i = 1'b0;
        check("t3_rdNum",      {27'd0, bus.rdNum_o},  32'd7);
        check("t3_rdVal",      bus.rdVal_o,           32'h77);
        check("t3_hazard_clr", {31'd0, bus.hazard_o}, 32'd0);

        // set beats clear on rd=9
        bus.rs1Num_i     = 5'd0;
        bus.issueValid_i = 1'b1;
        bus.issueRd_i    = 5'd9;
        bus.exValid_i    = 1'b1;
        bus.exRd_i       = 5'd9;
        bus.exData_i     = 32'h99;
        #1;
        check("t4_exReady", {31'd0, bus.exReady_o}, 32'd1);
        tick();
        bus.issueValid_i = 1'b0;
        bus.exValid_i    = 1'b0;
        bus.rs2Num_i     = 5'd9;
        #1;
        check("t4_hazard_rs2", {31'd0, bus.hazard_o},   32'd1);
        check("t4_regWrite",   {31'd0, bus.regWrite_o}, 32'd1);
        check("t4_rdNum",      {27'd0, bus.rdNum_o},    32'd9);

        // x0 handling
        bus.rs2Num_i     = 5'd0;
        bus.issueValid_i = 1'b1;
        bus.issueRd_i    = 5'd0;
        tick();
        bus.issueValid_i = 1'b0;
        bus.rs1Num_i     = 5'd0;
        #1;
        check("t5_hazard_x0", {31'd0, bus.hazard_o}, 32'd0);
        bus.exValid_i = 1'b1;
        bus.exRd_i    = 5'd0;
        bus.exData_i  = 32'h55;
        #1;
        check("t5_exReady", {31'd0, bus.exReady_o}, 32'd1);
        tick();
        bus.exValid_i = 1'b0;
        check("t5_regWrite", {31'd0, bus.regWrite_o}, 32'd0);
        check("t5_rdVal",    bus.rdVal_o,             32'h55);
        check("t5_hazard",   {31'd0, bus.hazard_o},   32'd0);

        // flush with concurrent issue
        bus.issueValid_i = 1'b1;
        bus.issueRd_i    = 5'd2;
        tick();
        bus.issueRd_i    = 5'd3;
        tick();
        bus.issueValid_i = 1'b0;
        bus.rs1Num_i     = 5'd2;
        bus.rs2Num_i     = 5'd3;
        #1;
        check("t6_pre_hazard_2_3", {31'd0, bus.hazard_o}, 32'd1);
        bus.rs1Num_i = 5'd9;
        bus.rs2Num_i = 5'd0;
        #1;
        check("t6_pre_hazard_9", {31'd0, bus.hazard_o}, 32'd1);
        bus.flush_i      = 1'b1;
        bus.issueValid_i = 1'b1;
        bus.issueRd_i    = 5'd6;
        tick();
        bus.flush_i      = 1'b0;
        bus.issueValid_i = 1'b0;
        bus.rs1Num_i     = 5'd2;
        bus.rs2Num_i     = 5'd3;
        #1;
        check("t6_flush_2_3", {31'd0, bus.hazard_o}, 32'd0);
        bus.rs1Num_i = 5'd9;
        bus.rs2Num_i = 5'd0;
        #1;
        check("t6_flush_9", {31'd0, bus.hazard_o}, 32'd0);
        bus.rs1Num_i = 5'd6;
        #1;
        check("t6_keep_6", {31'd0, bus.hazard_o}, 32'd1);

        // async reset while a write is in flight
        bus.exValid_i = 1'b1;
        bus.exRd_i    = 5'd10;
        bus.exData_i  = 32'hAA;
        tick();
        check("t7_regWrite_pre", {31'd0, bus.regWrite_o}, 32'd1);
        check("t7_rdNum_pre",    {27'd0, bus.rdNum_o},    32'd10);
        bus.exRd_i   = 5'd11;
        bus.exData_i = 32'hBB;
        #1;
        check("t7_exReady_pre", {31'd0, bus.exReady_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_exReady",  {31'd0, bus.exReady_o},  32'd0);
        check("t7_rst_regWrite", {31'd0, bus.regWrite_o}, 32'd0);
        check("t7_rst_rdNum",    {27'd0, bus.rdNum_o},    32'd0);
        check("t7_rst_rdVal",    bus.rdVal_o,             32'd0);
        for (int r = 1; r < 32; r++) begin
            bus.rs1Num_i = r[4:0];
            bus.rs2Num_i = r[4:0];
            #1;
            check("t7_rst_pending", {31'd0, bus.hazard_o}, 32'd0);
        end
        bus.exValid_i = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("t7_post_regWrite_a", {31'd0, bus.regWrite_o}, 32'd0);
        tick();
        check("t7_post_regWrite_b", {31'd0, bus.regWrite_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
